// File: rtl/spi_xfer_sequencer.sv
// Transaction sequencer between the I2C byte front-end and the SPI byte engine.
// A one-byte header selects WRITE / READ / WRITE_READ and the read count.
// The sequencer owns spi_cs_n, spacing it from engine activity with
// programmable setup and hold gaps. Read data lands in a 16-entry FIFO that
// the I2C side drains at its own pace.
//
//   state        | meaning
//   -------------+----------------------------------------------------------
//   IDLE         | CS high, waiting for a header byte
//   SETUP        | CS low, counting the CS_SETUP gap before engine activity
//   WR_WAIT_BYTE | write phase, waiting for the next data byte or a stop
//   WR_XFER      | engine shifting a write byte; stop requests are latched
//   RD_XFER      | issuing N dummy (0x00) bytes, pushing MISO into the FIFO
//   HOLD         | CS low, counting the CS_HOLD gap after the last byte
//   DRAIN_ERR    | reserved opcode: swallow bytes until stop, CS stays high

module spi_xfer_sequencer #(
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       rx_stop,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ack,
    output logic       eng_start,
    output logic [7:0] eng_wdata,
    input  logic       eng_done,
    input  logic [7:0] eng_rdata,
    output logic       spi_cs_n,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        WR_WAIT_BYTE,
        WR_XFER,
        RD_XFER,
        HOLD,
        DRAIN_ERR
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WR_RD = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    // Gap timers are down-counters that expire when they reach zero, so the
    // load value is one less than the number of cycles spent in the state.
    localparam logic [7:0] SETUP_LOAD = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LOAD  = 8'(CS_HOLD - 1);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  nm1_q, nm1_d;
    logic [7:0]  tmr_q, tmr_d;
    logic [3:0]  rd_left_q, rd_left_d;
    logic        stop_pend_q, stop_pend_d;
    logic        start_q, start_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        cs_n_q, cs_n_d;
    logic        err_q, err_d;
    logic        flush;
    logic        push;
    logic        stop_go;
    logic        rx_fire;

    logic [7:0]  fifo_mem [16];
    logic [3:0]  wr_ptr_q;
    logic [3:0]  rd_ptr_q;
    logic [4:0]  fifo_cnt_q;
    logic        push_ok;
    logic        pop;

    assign rx_ready  = (state_q == IDLE) || (state_q == WR_WAIT_BYTE) ||
                       (state_q == DRAIN_ERR);
    assign rx_fire   = rx_valid & rx_ready;
    assign busy      = (state_q != IDLE);
    assign err       = err_q;
    assign spi_cs_n  = cs_n_q;
    assign eng_start = start_q;
    assign eng_wdata = wdata_q;

    // State and datapath registers; reset drops CS immediately with no hold gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 2'b00;
            nm1_q       <= 4'd0;
            tmr_q       <= 8'd0;
            rd_left_q   <= 4'd0;
            stop_pend_q <= 1'b0;
            start_q     <= 1'b0;
            wdata_q     <= 8'h00;
            cs_n_q      <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            nm1_q       <= nm1_d;
            tmr_q       <= tmr_d;
            rd_left_q   <= rd_left_d;
            stop_pend_q <= stop_pend_d;
            start_q     <= start_d;
            wdata_q     <= wdata_d;
            cs_n_q      <= cs_n_d;
            err_q       <= err_d;
        end
    end

    // Next-state and register-input logic.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        nm1_d       = nm1_q;
        tmr_d       = tmr_q;
        rd_left_d   = rd_left_q;
        stop_pend_d = stop_pend_q;
        start_d     = 1'b0;
        wdata_d     = wdata_q;
        err_d       = err_q;
        flush       = 1'b0;
        push        = 1'b0;
        stop_go     = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    if (rx_data[7:6] == OP_RSVD) begin
                        err_d   = 1'b1;
                        state_d = DRAIN_ERR;
                    end else begin
                        op_d        = rx_data[7:6];
                        nm1_d       = rx_data[3:0];
                        err_d       = 1'b0;
                        flush       = 1'b1;
                        stop_pend_d = 1'b0;
                        tmr_d       = SETUP_LOAD;
                        state_d     = SETUP;
                    end
                end
            end

            SETUP: begin
                if (tmr_q == 8'd0) begin
                    if (op_q == OP_READ) begin
                        state_d   = RD_XFER;
                        start_d   = 1'b1;
                        wdata_d   = 8'h00;
                        rd_left_d = nm1_q;
                    end else begin
                        state_d = WR_WAIT_BYTE;
                    end
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end

            WR_WAIT_BYTE: begin
                if (rx_fire) begin
                    // A stop arriving with the byte is honoured after the byte.
                    wdata_d     = rx_data;
                    start_d     = 1'b1;
                    stop_pend_d = rx_stop;
                    state_d     = WR_XFER;
                end else if (rx_stop) begin
                    stop_go = 1'b1;
                end
            end

            WR_XFER: begin
                if (rx_stop) begin
                    stop_pend_d = 1'b1;
                end
                if (eng_done) begin
                    if (stop_pend_q || rx_stop) begin
                        stop_go = 1'b1;
                    end else begin
                        state_d = WR_WAIT_BYTE;
                    end
                end
            end

            RD_XFER: begin
                if (eng_done) begin
                    push = 1'b1;
                    if (rd_left_q == 4'd0) begin
                        tmr_d   = HOLD_LOAD;
                        state_d = HOLD;
                    end else begin
                        rd_left_d = rd_left_q - 4'd1;
                        start_d   = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (tmr_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q - 8'd1;
                end
            end

            DRAIN_ERR: begin
                if (rx_stop) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // End of the write phase: plain WRITE closes out, WRITE_READ turns around.
        if (stop_go) begin
            stop_pend_d = 1'b0;
            if (op_q == OP_WR_RD) begin
                state_d   = RD_XFER;
                start_d   = 1'b1;
                wdata_d   = 8'h00;
                rd_left_d = nm1_q;
            end else begin
                tmr_d   = HOLD_LOAD;
                state_d = HOLD;
            end
        end

        cs_n_d = (state_d == IDLE) || (state_d == DRAIN_ERR);
    end

    assign pop     = tx_ack & (fifo_cnt_q != 5'd0);
    assign push_ok = push & ((fifo_cnt_q != 5'd16) | pop);

    // Read FIFO pointers and occupancy; a new header discards unread data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= 4'd0;
            rd_ptr_q   <= 4'd0;
            fifo_cnt_q <= 5'd0;
        end else if (flush) begin
            wr_ptr_q   <= 4'd0;
            rd_ptr_q   <= 4'd0;
            fifo_cnt_q <= 5'd0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 4'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 4'd1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 5'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 5'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

    // FIFO storage; contents need no reset because occupancy gates the output.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= eng_rdata;
        end
    end

    assign tx_valid = (fifo_cnt_q != 5'd0);
    assign tx_data  = tx_valid ? fifo_mem[rd_ptr_q] : 8'h00;

endmodule
